// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU register-file helpers: load sequencer states,
// register-pair indices and the default register count.
package dcpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    WR_LO,
    RD_HI,
    WR_HI,
    INC_LO,
    INC_HI,
    DONE
  } load_state_e;

  // A pair p occupies registers {p,0} (low byte) and {p,1} (high byte).
  localparam logic [2:0] PAIR_AB = 3'd0;
  localparam logic [2:0] PAIR_CD = 3'd1;
  localparam logic [2:0] PAIR_EF = 3'd2;
  localparam logic [2:0] PAIR_GH = 3'd3;
  localparam logic [2:0] PAIR_SP = 3'd4;
  localparam logic [2:0] PAIR_PC = 3'd5;

  localparam int REGCOUNT_DEFAULT = 12;

endpackage

// File: rtl/mem_loader.sv
// Loads a byte or little-endian word from memory, addressed by a register pair,
// into the register file, optionally writing the advanced pointer back.
module mem_loader
  import dcpu_pkg::*;
#(
  parameter int REGCOUNT = REGCOUNT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_ptr_sel,
  input  logic [3:0]  i_dst_sel,
  input  logic        i_word,
  input  logic        i_postinc,
  output logic [2:0]  o_addr_sel,
  input  logic [15:0] i_addr,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_dat,
  output logic [7:0]  o_load_dat,
  output logic [3:0]  o_load_reg_sel,
  output logic        o_load,
  output logic        o_busy,
  output logic        o_done
);

  load_state_e state_q, state_d;
  logic [2:0]  ptrSel_q, ptrSel_d;
  logic [3:0]  dstSel_q, dstSel_d;
  logic        word_q, word_d;
  logic        postinc_q, postinc_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  data_q, data_d;

  logic [3:0]  loIdx;
  logic [3:0]  hiIdx;
  logic [15:0] newPtr;

  function automatic logic inRange(input logic [3:0] idx);
    return {28'd0, idx} < 32'(REGCOUNT);
  endfunction

  assign loIdx  = word_q ? {dstSel_q[3:1], 1'b0} : dstSel_q;
  assign hiIdx  = {dstSel_q[3:1], 1'b1};
  assign newPtr = ptr_q + (word_q ? 16'd2 : 16'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      ptrSel_q  <= '0;
      dstSel_q  <= '0;
      word_q    <= 1'b0;
      postinc_q <= 1'b0;
      ptr_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptrSel_q  <= ptrSel_d;
      dstSel_q  <= dstSel_d;
      word_q    <= word_d;
      postinc_q <= postinc_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptrSel_d       = ptrSel_q;
    dstSel_d       = dstSel_q;
    word_d         = word_q;
    postinc_d      = postinc_q;
    ptr_d          = ptr_q;
    data_d         = data_q;
    o_addr_sel     = ptrSel_q;
    o_mem_addr     = '0;
    o_mem_rd       = 1'b0;
    o_load_dat     = '0;
    o_load_reg_sel = '0;
    o_load         = 1'b0;
    o_busy         = 1'b1;
    o_done         = 1'b0;

    case (state_q)
      IDLE: begin
        o_busy     = 1'b0;
        o_addr_sel = i_ptr_sel;
        if (i_start) begin
          ptrSel_d  = i_ptr_sel;
          dstSel_d  = i_dst_sel;
          word_d    = i_word;
          postinc_d = i_postinc;
          ptr_d     = i_addr;
          state_d   = RD_LO;
        end
      end
      RD_LO: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = ptr_q;
        if (i_mem_ack) begin
          data_d  = i_mem_dat;
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        o_load_reg_sel = loIdx;
        o_load_dat     = data_q;
        o_load         = inRange(loIdx);
        if (word_q)         state_d = RD_HI;
        else if (postinc_q) state_d = INC_LO;
        else                state_d = DONE;
      end
      RD_HI: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = ptr_q + 16'd1;
        if (i_mem_ack) begin
          data_d  = i_mem_dat;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        o_load_reg_sel = hiIdx;
        o_load_dat     = data_q;
        o_load         = inRange(hiIdx);
        state_d        = postinc_q ? INC_LO : DONE;
      end
      // Pointer write-back comes last so it wins when the destination is the pointer pair.
      INC_LO: begin
        o_load_reg_sel = {ptrSel_q, 1'b0};
        o_load_dat     = newPtr[7:0];
        o_load         = 1'b1;
        state_d        = INC_HI;
      end
      INC_HI: begin
        o_load_reg_sel = {ptrSel_q, 1'b1};
        o_load_dat     = newPtr[15:8];
        o_load         = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset quiets every strobe and bus immediately, not just from the next cycle.
    if (i_reset) begin
      state_d        = IDLE;
      o_mem_rd       = 1'b0;
      o_load         = 1'b0;
      o_done         = 1'b0;
      o_busy         = 1'b0;
      o_mem_addr     = '0;
      o_load_dat     = '0;
      o_load_reg_sel = '0;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: register-file and memory models with
// programmable ack latency, plus a log of every register write and memory read.
module tb_mem_loader;
  import dcpu_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_ptr_sel;
  logic [3:0]  i_dst_sel;
  logic        i_word;
  logic        i_postinc;
  logic [2:0]  o_addr_sel;
  logic [15:0] i_addr;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        i_mem_ack;
  logic [7:0]  i_mem_dat;
  logic [7:0]  o_load_dat;
  logic [3:0]  o_load_reg_sel;
  logic        o_load;
  logic        o_busy;
  logic        o_done;

  logic [7:0]  rf [16];
  logic [7:0]  mem [logic [15:0]];
  int          ackDelay;
  int          waitCnt;
  int          rdCycles;
  int          addrChanges;
  int          exclViol;
  logic [15:0] firstAddr;
  logic [11:0] logQ [$];
  logic [15:0] readQ [$];
  int          logBase;
  int          readBase;
  int          checkCount;
  int          errorCount;
  int          cycles;

  mem_loader #(.REGCOUNT(12)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_ptr_sel(i_ptr_sel), .i_dst_sel(i_dst_sel), .i_word(i_word),
    .i_postinc(i_postinc), .o_addr_sel(o_addr_sel), .i_addr(i_addr),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_ack(i_mem_ack),
    .i_mem_dat(i_mem_dat), .o_load_dat(o_load_dat),
    .o_load_reg_sel(o_load_reg_sel), .o_load(o_load), .o_busy(o_busy),
    .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  assign i_addr = {rf[{o_addr_sel, 1'b1}], rf[{o_addr_sel, 1'b0}]};

  function automatic logic [7:0] memRead(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Every register write strobe is logged as {index, data}.
  always @(posedge i_clk) begin
    if (o_load) logQ.push_back({o_load_reg_sel, o_load_dat});
  end

  // Memory answers after ackDelay wait cycles and checks address stability.
  initial begin
    i_mem_ack   = 1'b0;
    i_mem_dat   = 8'h00;
    waitCnt     = 0;
    rdCycles    = 0;
    addrChanges = 0;
    exclViol    = 0;
    firstAddr   = '0;
    forever begin
      @(negedge i_clk);
      if (o_mem_rd && o_load) exclViol++;
      if (o_mem_rd) begin
        if (waitCnt == 0) firstAddr = o_mem_addr;
        else if (o_mem_addr != firstAddr) addrChanges++;
        rdCycles++;
        if (waitCnt >= ackDelay) begin
          i_mem_ack = 1'b1;
          i_mem_dat = memRead(o_mem_addr);
          readQ.push_back(o_mem_addr);
          waitCnt   = 0;
        end else begin
          i_mem_ack = 1'b0;
          i_mem_dat = 8'h00;
          waitCnt++;
        end
      end else begin
        i_mem_ack = 1'b0;
        waitCnt   = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [11:0] logAt(input int i);
    return (logBase + i < logQ.size()) ? logQ[logBase + i] : 12'hFFF;
  endfunction

  function automatic logic [15:0] readAt(input int i);
    return (readBase + i < readQ.size()) ? readQ[readBase + i] : 16'hDEAD;
  endfunction

  task automatic markLogs();
    logBase  = logQ.size();
    readBase = readQ.size();
  endtask

  task automatic applyStimulus(input logic [2:0] p, input logic [3:0] d,
                               input logic w, input logic pi);
    i_ptr_sel = p;
    i_dst_sel = d;
    i_word    = w;
    i_postinc = pi;
    i_start   = 1'b1;
    @(negedge i_clk);
    i_start   = 1'b0;
  endtask

  // Counts negedges from the start cycle until o_done; 100 means it never came.
  task automatic waitDone(input bit glitch, output int n);
    n = 1;
    while (!o_done && n < 100) begin
      @(negedge i_clk);
      n++;
      if (glitch && n == 2) begin
        i_start   = 1'b1;
        i_ptr_sel = PAIR_PC;
        i_dst_sel = 4'd9;
      end
      if (glitch && n == 3) i_start = 1'b0;
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    ackDelay   = 0;
    logBase    = 0;
    readBase   = 0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    i_reset   = 1'b1;
    i_start   = 1'b1;
    i_ptr_sel = PAIR_AB;
    i_dst_sel = 4'd0;
    i_word    = 1'b0;
    i_postinc = 1'b0;
    repeat (3) @(negedge i_clk);

    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset done", o_done, 0);
    checkOutput("reset mem_rd", o_mem_rd, 0);
    checkOutput("reset load", o_load, 0);
    checkOutput("reset mem_addr", o_mem_addr, 0);
    checkOutput("reset load_dat", o_load_dat, 0);
    checkOutput("reset reg_sel", o_load_reg_sel, 0);
    i_start = 1'b0;
    i_reset = 1'b0;
    i_ptr_sel = PAIR_PC;
    @(negedge i_clk);
    checkOutput("idle busy", o_busy, 0);
    checkOutput("idle addr_sel", o_addr_sel, PAIR_PC);

    // Byte load from AB=0x1234 into reg 2.
    rf[0] = 8'h34; rf[1] = 8'h12;
    mem[16'h1234] = 8'h5A;
    markLogs();
    applyStimulus(PAIR_AB, 4'd2, 1'b0, 1'b0);
    waitDone(1'b0, cycles);
    checkOutput("byte done latency", cycles, 3);
    checkOutput("byte nwrites", logQ.size() - logBase, 1);
    checkOutput("byte write0", logAt(0), {4'd2, 8'h5A});
    checkOutput("byte read addr", readAt(0), 16'h1234);
    @(negedge i_clk);
    checkOutput("byte back idle", o_busy, 0);

    // Word load with post-increment through GH=0x00FF.
    rf[6] = 8'hFF; rf[7] = 8'h00;
    mem[16'h00FF] = 8'h11; mem[16'h0100] = 8'h22;
    markLogs();
    applyStimulus(PAIR_GH, 4'd0, 1'b1, 1'b1);
    waitDone(1'b0, cycles);
    checkOutput("word done latency", cycles, 7);
    checkOutput("word nwrites", logQ.size() - logBase, 4);
    checkOutput("word write0", logAt(0), {4'd0, 8'h11});
    checkOutput("word write1", logAt(1), {4'd1, 8'h22});
    checkOutput("word write2", logAt(2), {4'd6, 8'h01});
    checkOutput("word write3", logAt(3), {4'd7, 8'h01});
    checkOutput("word read lo", readAt(0), 16'h00FF);
    checkOutput("word read hi", readAt(1), 16'h0100);
    @(negedge i_clk);

    // Pointer wrap: SP=0xFFFF, word, post-increment.
    rf[8] = 8'hFF; rf[9] = 8'hFF;
    mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB;
    markLogs();
    applyStimulus(PAIR_SP, 4'd4, 1'b1, 1'b1);
    waitDone(1'b0, cycles);
    checkOutput("wrap read lo", readAt(0), 16'hFFFF);
    checkOutput("wrap read hi", readAt(1), 16'h0000);
    checkOutput("wrap write0", logAt(0), {4'd4, 8'hAA});
    checkOutput("wrap write1", logAt(1), {4'd5, 8'hBB});
    checkOutput("wrap ptr lo", logAt(2), {4'd8, 8'h01});
    checkOutput("wrap ptr hi", logAt(3), {4'd9, 8'h00});
    @(negedge i_clk);

    // Slow memory with stray start pulses during the wait.
    rf[0] = 8'h11; rf[1] = 8'h22;
    mem[16'h2211] = 8'h77;
    ackDelay    = 5;
    rdCycles    = 0;
    addrChanges = 0;
    markLogs();
    applyStimulus(PAIR_AB, 4'd3, 1'b0, 1'b0);
    waitDone(1'b1, cycles);
    checkOutput("slow rd cycles", rdCycles, 6);
    checkOutput("slow addr changes", addrChanges, 0);
    checkOutput("slow read addr", readAt(0), 16'h2211);
    checkOutput("slow done latency", cycles, 8);
    repeat (3) @(negedge i_clk);
    checkOutput("slow busy after", o_busy, 0);
    checkOutput("slow nwrites", logQ.size() - logBase, 1);
    checkOutput("slow write0", logAt(0), {4'd3, 8'h77});
    ackDelay = 0;

    // Out-of-range destinations are skipped; reg 11 is the last valid one.
    rf[4] = 8'hAA; rf[5] = 8'hBB;
    mem[16'hBBAA] = 8'h3C;
    markLogs();
    applyStimulus(PAIR_EF, 4'd13, 1'b0, 1'b0);
    waitDone(1'b0, cycles);
    checkOutput("dst13 done latency", cycles, 3);
    checkOutput("dst13 nwrites", logQ.size() - logBase, 0);
    @(negedge i_clk);
    markLogs();
    applyStimulus(PAIR_EF, 4'd12, 1'b0, 1'b0);
    waitDone(1'b0, cycles);
    checkOutput("dst12 nwrites", logQ.size() - logBase, 0);
    @(negedge i_clk);
    markLogs();
    applyStimulus(PAIR_EF, 4'd11, 1'b0, 1'b0);
    waitDone(1'b0, cycles);
    checkOutput("dst11 write0", logAt(0), {4'd11, 8'h3C});
    @(negedge i_clk);

    // Reset while waiting in RD_HI aborts the high-byte write.
    rf[2] = 8'h5A; rf[3] = 8'h00;
    mem[16'h005A] = 8'h01;
    markLogs();
    applyStimulus(PAIR_CD, 4'd10, 1'b1, 1'b1);
    @(negedge i_clk);
    ackDelay = 50;
    @(negedge i_clk);
    checkOutput("abort in rd_hi", o_mem_rd, 1);
    checkOutput("abort hi addr", o_mem_addr, 16'h005B);
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("abort mem_rd", o_mem_rd, 0);
    checkOutput("abort busy", o_busy, 0);
    i_reset  = 1'b0;
    ackDelay = 0;
    repeat (4) @(negedge i_clk);
    checkOutput("abort nwrites", logQ.size() - logBase, 1);
    checkOutput("abort write0", logAt(0), {4'd10, 8'h01});
    checkOutput("abort idle", o_busy, 0);

    checkOutput("mem_rd/load exclusive", exclViol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
